// File: rtl/sram_req_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// sram_req_arbiter_pkg
//   Shared definitions for the SRAM-like request arbiter and its owner FIFO:
//   bus widths, the owner tag values and the grant-holding FSM encoding.
// -----------------------------------------------------------------------------
package sram_req_arbiter_pkg;

  // SRAM-like bus widths
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int STRB_W = 4;

  // Owner tag stored per outstanding transaction
  localparam logic OWNER_INST = 1'b0;
  localparam logic OWNER_DATA = 1'b1;

  // Grant FSM: FREE arbitrates every cycle, the HOLD states pin the owner
  // while a presented request is waiting for mem_addr_ok.
  typedef enum logic [1:0] {
    GRANT_FREE      = 2'd0,
    GRANT_HOLD_INST = 2'd1,
    GRANT_HOLD_DATA = 2'd2
  } grant_state_e;

  // HOLD state that pins a given owner
  function automatic grant_state_e hold_state_for(input logic owner);
    return (owner == OWNER_DATA) ? GRANT_HOLD_DATA : GRANT_HOLD_INST;
  endfunction

endpackage

// File: rtl/sram_req_arbiter_owner_fifo.sv
// -----------------------------------------------------------------------------
// sram_req_arbiter_owner_fifo
//   Small FIFO of 1-bit owner tags, one entry per transaction accepted by
//   memory and not yet answered. Head is presented combinationally so the
//   response can be routed in the same cycle it arrives.
//
// Ports:
//   clk, resetn   clock, asynchronous active-low reset (empties the FIFO)
//   push, push_tag  enqueue push_tag (ignored while full)
//   pop           dequeue the head (ignored while empty)
//   full, empty   occupancy flags, from the registered count
//   head          tag at the read pointer (valid when !empty)
// -----------------------------------------------------------------------------
module sram_req_arbiter_owner_fifo #(
  parameter int DEPTH = 2
) (
  input  logic clk,
  input  logic resetn,
  input  logic push,
  input  logic push_tag,
  input  logic pop,
  output logic full,
  output logic empty,
  output logic head
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [DEPTH-1:0] tag_reg;
  logic [PW-1:0]    wr_ptr_reg;
  logic [PW-1:0]    rd_ptr_reg;
  logic [CW-1:0]    count_reg;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  assign full  = (count_reg == FULL_CNT);
  assign empty = (count_reg == '0);
  assign head  = tag_reg[rd_ptr_reg];

  // Full blocks a push even if a pop happens in the same cycle; the caller
  // never presents a push while full, this is just a guard.
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
      always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
          tag_reg[gi] <= 1'b0;
        end else if (do_push && (wr_ptr_reg == PW'(gi))) begin
          tag_reg[gi] <= push_tag;
        end
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= ptr_inc(wr_ptr_reg);
      if (do_pop)  rd_ptr_reg <= ptr_inc(rd_ptr_reg);
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/sram_req_arbiter.sv
// -----------------------------------------------------------------------------
// sram_req_arbiter
//   Merges the core's instruction-fetch and load/store SRAM-like channels onto
//   one SRAM-like memory port with up to MAX_OUTST transactions in flight.
//   Requests pass through combinationally; data wins contention unless inst
//   has lost STREAK_MAX times in a row. An owner FIFO remembers who issued
//   each accepted request so in-order responses are routed back.
//
// Ports:
//   clk, resetn                     clock, asynchronous active-low reset
//   inst_req/addr -> inst_addr_ok   fetch request channel
//   inst_data_ok, inst_rdata        fetch response
//   data_req/wr/wstrb/addr/wdata -> data_addr_ok   load/store request
//   data_data_ok, data_rdata        load/store response (store ack too)
//   mem_req/wr/wstrb/addr/wdata, mem_addr_ok       merged request
//   mem_data_ok, mem_rdata          merged response
//   err_orphan                      sticky: response with nothing outstanding
// -----------------------------------------------------------------------------
module sram_req_arbiter
  import sram_req_arbiter_pkg::*;
#(
  parameter int MAX_OUTST  = 2,
  parameter int STREAK_MAX = 4
) (
  input  logic              clk,
  input  logic              resetn,
  // instruction fetch channel
  input  logic              inst_req,
  input  logic [ADDR_W-1:0] inst_addr,
  output logic              inst_addr_ok,
  output logic              inst_data_ok,
  output logic [DATA_W-1:0] inst_rdata,
  // load/store channel
  input  logic              data_req,
  input  logic              data_wr,
  input  logic [STRB_W-1:0] data_wstrb,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic [DATA_W-1:0] data_wdata,
  output logic              data_addr_ok,
  output logic              data_data_ok,
  output logic [DATA_W-1:0] data_rdata,
  // merged memory channel
  output logic              mem_req,
  output logic              mem_wr,
  output logic [STRB_W-1:0] mem_wstrb,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_addr_ok,
  input  logic              mem_data_ok,
  input  logic [DATA_W-1:0] mem_rdata,
  // status
  output logic              err_orphan
);

  localparam int SW = $clog2(STREAK_MAX + 1);
  localparam logic [SW-1:0] STREAK_LIM = SW'(STREAK_MAX);

  grant_state_e  state_reg;
  grant_state_e  state_next;
  logic [SW-1:0] streak_reg;
  logic          err_orphan_reg;

  logic grant_data;     // 1 = data channel owns the bus this cycle
  logic sel_req;
  logic mem_hs;
  logic inst_hs;
  logic data_hs;
  logic fifo_full;
  logic fifo_empty;
  logic fifo_head;
  logic streak_force;

  // ---------------------------------------------------------------------------
  // Grant FSM
  // ---------------------------------------------------------------------------
  assign streak_force = (streak_reg == STREAK_LIM);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_reg <= GRANT_FREE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    grant_data = OWNER_INST;
    state_next = GRANT_FREE;

    case (state_reg)
      GRANT_HOLD_INST: grant_data = OWNER_INST;
      GRANT_HOLD_DATA: grant_data = OWNER_DATA;
      default: begin
        // Data wins ties unless inst has been starved for STREAK_MAX grants.
        grant_data = data_req & ~(inst_req & streak_force);
      end
    endcase

    // A presented but unaccepted request keeps its owner next cycle, so a
    // streak change cannot move a request to the other channel mid-handshake.
    if (mem_req && !mem_addr_ok) begin
      state_next = hold_state_for(grant_data);
    end
  end

  // ---------------------------------------------------------------------------
  // Request path (combinational)
  // ---------------------------------------------------------------------------
  assign sel_req   = grant_data ? data_req : inst_req;
  assign mem_req   = sel_req & ~fifo_full;
  assign mem_wr    = grant_data & data_wr;
  assign mem_wstrb = grant_data ? data_wstrb : '0;
  assign mem_addr  = grant_data ? data_addr : inst_addr;
  assign mem_wdata = grant_data ? data_wdata : '0;

  assign mem_hs  = mem_req & mem_addr_ok;
  assign inst_hs = mem_hs & ~grant_data;
  assign data_hs = mem_hs & grant_data;

  assign inst_addr_ok = inst_hs;
  assign data_addr_ok = data_hs;

  // ---------------------------------------------------------------------------
  // Starvation streak: counts data wins while inst is waiting
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      streak_reg <= '0;
    end else if (inst_hs || !inst_req) begin
      streak_reg <= '0;
    end else if (data_hs && !streak_force) begin
      streak_reg <= streak_reg + 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Owner tracking
  // ---------------------------------------------------------------------------
  sram_req_arbiter_owner_fifo #(
    .DEPTH (MAX_OUTST)
  ) u_owner_fifo (
    .clk      (clk),
    .resetn   (resetn),
    .push     (mem_hs),
    .push_tag (grant_data),
    .pop      (mem_data_ok),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .head     (fifo_head)
  );

  // ---------------------------------------------------------------------------
  // Response path (combinational)
  // ---------------------------------------------------------------------------
  assign inst_data_ok = mem_data_ok & ~fifo_empty & (fifo_head == OWNER_INST);
  assign data_data_ok = mem_data_ok & ~fifo_empty & (fifo_head == OWNER_DATA);
  assign inst_rdata   = mem_rdata;
  assign data_rdata   = mem_rdata;

  // A response with nothing outstanding is dropped but remembered.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      err_orphan_reg <= 1'b0;
    end else if (mem_data_ok && fifo_empty) begin
      err_orphan_reg <= 1'b1;
    end
  end

  assign err_orphan = err_orphan_reg;

endmodule

// File: tb/tb_sram_req_arbiter.sv
// -----------------------------------------------------------------------------
// tb_sram_req_arbiter
//   Directed scenarios plus a randomized phase. A transaction-level model
//   (outstanding count, starvation streak, held owner) predicts the request
//   side each cycle; accepted requests push their expected response into a
//   scoreboard that an independent monitor drains as responses appear.
// -----------------------------------------------------------------------------
module tb_sram_req_arbiter;

  localparam int MAX_OUTST  = 2;
  localparam int STREAK_MAX = 4;

  logic        clk = 1'b0;
  logic        resetn;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok, inst_data_ok;
  logic [31:0] inst_rdata;
  logic        data_req, data_wr;
  logic [3:0]  data_wstrb;
  logic [31:0] data_addr, data_wdata;
  logic        data_addr_ok, data_data_ok;
  logic [31:0] data_rdata;
  logic        mem_req, mem_wr;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_addr_ok, mem_data_ok;
  logic [31:0] mem_rdata;
  logic        err_orphan;

  always #5 clk = ~clk;

  sram_req_arbiter #(
    .MAX_OUTST  (MAX_OUTST),
    .STREAK_MAX (STREAK_MAX)
  ) dut (
    .clk          (clk),
    .resetn       (resetn),
    .inst_req     (inst_req),
    .inst_addr    (inst_addr),
    .inst_addr_ok (inst_addr_ok),
    .inst_data_ok (inst_data_ok),
    .inst_rdata   (inst_rdata),
    .data_req     (data_req),
    .data_wr      (data_wr),
    .data_wstrb   (data_wstrb),
    .data_addr    (data_addr),
    .data_wdata   (data_wdata),
    .data_addr_ok (data_addr_ok),
    .data_data_ok (data_data_ok),
    .data_rdata   (data_rdata),
    .mem_req      (mem_req),
    .mem_wr       (mem_wr),
    .mem_wstrb    (mem_wstrb),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_addr_ok  (mem_addr_ok),
    .mem_data_ok  (mem_data_ok),
    .mem_rdata    (mem_rdata),
    .err_orphan   (err_orphan)
  );

  typedef struct {
    logic        owner;   // 0 = inst, 1 = data
    logic [31:0] rdata;
  } resp_t;

  int          checks = 0;
  int          errors = 0;
  resp_t       sb[$];       // expected responses in acceptance order
  logic [31:0] mem_q[$];    // memory-side pending read data

  // reference model state
  int    outst;
  int    streak;
  int    hold;               // -1 = no held owner, else owner index
  bit    orphan_m;
  bit    last_hs, last_gd;
  string grant_log;
  logic [31:0] acc_rdata;
  logic        obs_mem_req, obs_daok, obs_ddok;
  logic [4:0]  obs_wr_strb;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic set_mem(input bit aok, input bit dok);
    mem_addr_ok = aok;
    mem_data_ok = dok;
    mem_rdata   = (dok && mem_q.size() > 0) ? mem_q[0] : $urandom;
  endtask

  // One clock cycle: called right after a posedge with inputs already set.
  task automatic step();
    bit full, gd, exp_req, hs, pop;
    #2;
    full = (outst >= MAX_OUTST);
    if (hold >= 0) gd = hold[0];
    else if (data_req && inst_req) gd = (streak < STREAK_MAX);
    else gd = data_req;
    exp_req = !full && (gd ? data_req : inst_req);
    hs  = exp_req && mem_addr_ok;
    pop = mem_data_ok && (outst > 0);

    check("mem_req", mem_req, exp_req);
    check("addr_ok", {inst_addr_ok, data_addr_ok}, {hs && !gd, hs && gd});
    if (exp_req)
      check("mem_fields", {mem_wr, mem_wstrb, mem_addr, mem_wdata},
            gd ? {data_wr, data_wstrb, data_addr, data_wdata}
               : {1'b0, 4'b0000, inst_addr, 32'h0});
    check("err_orphan", err_orphan, orphan_m);

    obs_mem_req = mem_req;
    obs_daok    = data_addr_ok;
    obs_ddok    = data_data_ok;
    obs_wr_strb = {mem_wr, mem_wstrb};
    if (inst_addr_ok)      grant_log = {grant_log, "I"};
    else if (data_addr_ok) grant_log = {grant_log, "D"};

    @(posedge clk);
    if (pop) void'(mem_q.pop_front());
    if (hs) begin
      sb.push_back('{gd, acc_rdata});
      mem_q.push_back(acc_rdata);
    end
    if (mem_data_ok && outst == 0) orphan_m = 1'b1;
    outst = outst + int'(hs) - int'(pop);
    if ((hs && !gd) || !inst_req) streak = 0;
    else if (hs && gd && streak < STREAK_MAX) streak++;
    hold = (exp_req && !mem_addr_ok) ? int'(gd) : -1;
    last_hs = hs;
    last_gd = gd;
    #1;
  endtask

  task automatic model_clear();
    outst = 0; streak = 0; hold = -1; orphan_m = 1'b0;
    sb.delete();
    mem_q.delete();
  endtask

  task automatic drain();
    inst_req = 1'b0;
    data_req = 1'b0;
    for (int i = 0; i < 50 && outst > 0; i++) begin
      set_mem(1'b0, 1'b1);
      step();
    end
    if (outst > 0) begin
      errors++;
      $display("FAIL drain_timeout: got %0d outstanding expected 0", outst);
    end
    set_mem(1'b0, 1'b0);
    step();
  endtask

  // Response monitor: independent of the stimulus process.
  always @(negedge clk) begin : monitor
    resp_t e;
    if (mem_data_ok && sb.size() > 0) begin
      e = sb.pop_front();
      check("rsp_owner", {inst_data_ok, data_data_ok}, e.owner ? 2'b01 : 2'b10);
      check("rsp_data", e.owner ? data_rdata : inst_rdata, e.rdata);
    end else begin
      check("rsp_idle", {inst_data_ok, data_data_ok}, 2'b00);
    end
  end

  initial begin
    bit inst_act, data_act;

    resetn = 1'b0;
    inst_req = 1'b0; inst_addr = '0;
    data_req = 1'b0; data_wr = 1'b0; data_wstrb = '0; data_addr = '0; data_wdata = '0;
    mem_addr_ok = 1'b0; mem_data_ok = 1'b0; mem_rdata = '0;
    acc_rdata = '0;
    grant_log = "";
    model_clear();
    repeat (2) @(posedge clk);
    #3;
    check("reset_outputs", {mem_req, inst_addr_ok, data_addr_ok, err_orphan}, 4'b0000);
    @(posedge clk);
    #1 resetn = 1'b1;

    // ---- single fetch ----
    inst_req = 1'b1; inst_addr = 32'h1c00_0000;
    acc_rdata = 32'h0280_0c0c;
    set_mem(1'b1, 1'b0); step();
    inst_req = 1'b0;
    set_mem(1'b0, 1'b0); step();
    set_mem(1'b0, 1'b1); step();
    set_mem(1'b0, 1'b0); step();

    // ---- contention: D,D,D,D,I,D ----
    grant_log = "";
    inst_req = 1'b1; data_req = 1'b1; data_wr = 1'b0; data_wstrb = '0;
    for (int i = 0; i < 6; i++) begin
      inst_addr = $urandom; data_addr = $urandom; acc_rdata = $urandom;
      set_mem(1'b1, mem_q.size() > 0);
      step();
    end
    checks++;
    if (grant_log != "DDDDID") begin
      errors++;
      $display("FAIL grant_order: got %s expected DDDDID", grant_log);
    end
    drain();

    // ---- full FIFO blocking ----
    data_req = 1'b1; data_wr = 1'b0;
    data_addr = 32'h100; acc_rdata = $urandom; set_mem(1'b1, 1'b0); step();
    data_addr = 32'h104; acc_rdata = $urandom; set_mem(1'b1, 1'b0); step();
    data_addr = 32'h108; acc_rdata = $urandom; set_mem(1'b1, 1'b0); step();
    check("full_block", {obs_mem_req, obs_daok}, 2'b00);
    set_mem(1'b1, 1'b1); step();
    check("full_pop_cycle_N", obs_daok, 1'b0);
    set_mem(1'b1, 1'b0); step();
    check("full_accept_N1", obs_daok, 1'b1);
    drain();

    // ---- interleaved ownership I, D, I ----
    inst_req = 1'b1; inst_addr = 32'h200; acc_rdata = 32'hA;
    set_mem(1'b1, 1'b0); step();
    inst_req = 1'b0; data_req = 1'b1; data_addr = 32'h300; acc_rdata = 32'hB;
    set_mem(1'b1, 1'b0); step();
    data_req = 1'b0; inst_req = 1'b1; inst_addr = 32'h204; acc_rdata = 32'hC;
    set_mem(1'b1, 1'b1); step();
    set_mem(1'b1, 1'b1); step();
    inst_req = 1'b0;
    drain();

    // ---- store ack ----
    data_req = 1'b1; data_wr = 1'b1; data_addr = 32'h800; data_wstrb = 4'b0011;
    data_wdata = 32'h1234; acc_rdata = $urandom;
    set_mem(1'b1, 1'b0); step();
    check("store_wr_strb", obs_wr_strb, 5'b1_0011);
    data_req = 1'b0; data_wr = 1'b0; data_wstrb = '0;
    set_mem(1'b0, 1'b1); step();
    check("store_ack", obs_ddok, 1'b1);

    // ---- orphan, then asynchronous reset mid-cycle ----
    set_mem(1'b0, 1'b1); step();
    set_mem(1'b0, 1'b0); step();
    check("orphan_sticky", err_orphan, 1'b1);
    inst_req = 1'b1; inst_addr = 32'h400; acc_rdata = $urandom;
    set_mem(1'b1, 1'b0); step();
    inst_req = 1'b0;
    #2 resetn = 1'b0;
    #1;
    check("reset_async", {err_orphan, mem_req, inst_addr_ok, data_addr_ok}, 4'b0000);
    model_clear();
    @(posedge clk);
    #1 resetn = 1'b1;
    set_mem(1'b0, 1'b1); step();   // in-flight response is now an orphan
    set_mem(1'b0, 1'b0); step();
    check("orphan_after_reset", err_orphan, 1'b1);

    // ---- randomized traffic ----
    inst_act = 1'b0; data_act = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (!inst_act && ($urandom % 3 == 0)) begin
        inst_act = 1'b1; inst_addr = $urandom;
      end
      if (!data_act && ($urandom % 2 == 0)) begin
        data_act = 1'b1; data_addr = $urandom; data_wr = $urandom % 2;
        data_wstrb = data_wr ? 4'($urandom) : 4'b0000; data_wdata = $urandom;
      end
      inst_req = inst_act; data_req = data_act;
      acc_rdata = $urandom;
      set_mem($urandom % 4 != 0, (mem_q.size() > 0) && ($urandom % 2 == 0));
      step();
      if (last_hs) begin
        if (last_gd) data_act = 1'b0;
        else inst_act = 1'b0;
      end
    end
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
